// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Brief    : Streams a program into instruction memory over a valid/ready
//             port, holds the core in reset for HOLD_CYCLES after the final
//             word, then releases it. Overflowing memory parks in an error
//             state until reset or reload.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  // A zero hold length still keeps the core in reset for one cycle.
  localparam int c_hold_eff = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int c_hold_w   = $clog2(c_hold_eff + 1);

  // Highest legal word index; a non-final word landing here overflows.
  localparam logic [ADDR_W:0] c_last_idx = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] c_one_cnt  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W:0]       r_count;
  logic [ADDR_W:0]       w_count_nxt;
  logic [c_hold_w-1:0]   r_hold;
  logic [c_hold_w-1:0]   w_hold_nxt;
  logic                  w_xfer;

  // Next-state, counters and status outputs derived from the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_hold_nxt  = r_hold;
    s_ready     = (r_state == LOAD);
    core_reset  = (r_state != RUN);
    done        = (r_state == RUN);
    error       = (r_state == ERR);
    // Reload wins over a simultaneous handshake: that word is dropped.
    w_xfer      = s_valid && (r_state == LOAD) && !reload;

    if (reload) begin
      w_state_nxt = LOAD;
      w_count_nxt = '0;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_xfer) begin
            w_count_nxt = r_count + c_one_cnt;
            if (s_last) begin
              w_state_nxt = HOLD;
              w_hold_nxt  = c_hold_w'(c_hold_eff);
            end else if (r_count == c_last_idx) begin
              w_state_nxt = ERR;
            end
          end
        end
        HOLD: begin
          w_hold_nxt = r_hold - c_hold_w'(1);
          if (r_hold <= c_hold_w'(1)) begin
            w_state_nxt = RUN;
          end
        end
        RUN:     w_state_nxt = RUN;
        ERR:     w_state_nxt = ERR;
        default: w_state_nxt = LOAD;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Write port lags the handshake by one cycle; it is not cancelled by reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= w_xfer;
      if (w_xfer) begin
        imem_addr  <= r_count[ADDR_W-1:0];
        imem_wdata <= s_data;
      end
    end
  end

  assign word_count = r_count;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address width; instruction memory depth is 2^ADDR_W words.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, meaning the number of cycles the core stays in reset after the last word is written.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (low = reset).
REQ-005 SHALL have port s_valid, input, 1, meaning a program word is offered.
REQ-006 SHALL have port s_data, input, 32, meaning the offered instruction word.
REQ-007 SHALL have port s_last, input, 1, meaning the offered word is the final word of the program.
REQ-008 SHALL have port s_ready, output, 1, meaning the loader accepts the offered word this cycle.
REQ-009 SHALL have port reload, input, 1, a single-cycle request to restart loading.
REQ-010 SHALL have port imem_we, output, 1, the instruction memory write enable.
REQ-011 SHALL have port imem_addr, output, ADDR_W, the instruction memory word address (PC[ADDR_W+1:2] equivalent).
REQ-012 SHALL have port imem_wdata, output, 32, the instruction memory write data.
REQ-013 SHALL have port core_reset, output, 1, active-high reset to the processor top module.
REQ-014 SHALL have port done, output, 1, meaning the program is loaded and the core is released.
REQ-015 SHALL have port error, output, 1, meaning the program overflowed memory.
REQ-016 SHALL have port word_count, output, ADDR_W+1, the number of words written in the current load.

Function
REQ-017 SHALL implement states LOAD, HOLD, RUN and ERR.
REQ-018 SHALL assert s_ready = 1 only in LOAD; a transfer occurs when s_valid=1 and s_ready=1 at a rising edge.
REQ-019 SHALL, one cycle after a transfer, drive imem_we=1 with imem_addr = word_count before the transfer and imem_wdata = s_data; imem_we SHALL be 0 in all other cycles.
REQ-020 SHALL increment word_count by 1 per transfer; word_count SHALL NOT wrap.
REQ-021 SHALL move LOAD->HOLD on a transfer with s_last=1 and load the hold counter with HOLD_CYCLES.
REQ-022 SHALL, in HOLD, decrement the hold counter each cycle and move to RUN in the cycle after the counter reaches 1, so that HOLD lasts exactly HOLD_CYCLES cycles.
REQ-023 SHALL treat HOLD_CYCLES=0 as 1.
REQ-024 SHALL hold core_reset=1 in LOAD, HOLD and ERR, and core_reset=0 only in RUN.
REQ-025 SHALL assert done=1 only in RUN.
REQ-026 SHALL accept a transfer with s_last=1 at word_count = 2^ADDR_W-1 as a normal final word and go to HOLD.
REQ-027 SHALL, on a transfer with s_last=0 at word_count = 2^ADDR_W-1, write that word and then enter ERR; the next offered word SHALL NOT be accepted.
REQ-028 SHALL, in ERR, hold error=1, s_ready=0 and core_reset=1 until reset or reload.
REQ-029 SHALL, on reload=1 in any state, go to LOAD and clear word_count, error and done on the next edge; the reload takes priority over any simultaneous transfer, which is dropped (not written, not counted).
REQ-030 SHALL keep an imem_we write already scheduled by a transfer in the previous cycle, even when reload is asserted.
REQ-031 SHALL ignore s_data and s_last when no transfer occurs.

Reset
REQ-032 SHALL, while reset=0, asynchronously force state LOAD, word_count=0, hold counter=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0 and error=0; s_ready SHALL be 1 from the first edge after release.
REQ-033 SHALL, on reset assertion during LOAD or HOLD, abort the load with no further writes; the next load starts at address 0.

Verification
REQ-034 SHALL cover: release reset, stream 3 words 0x20080005, 0x20090003, 0x01095020 (last on the 3rd) -> writes at addresses 0,1,2 one cycle after each transfer; core_reset falls exactly 4 cycles after the 3rd transfer; done=1; word_count=3.
REQ-035 SHALL cover: s_valid toggling every other cycle -> only handshaken words are written, with no address gaps.
REQ-036 SHALL cover, with ADDR_W=2: 4 words, last on the 4th -> RUN; separately, 5 words with no last -> 4 writes, then error=1, s_ready=0, 5th word not written, core_reset=1.
REQ-037 SHALL cover: reload pulse in RUN together with s_valid=1 -> core_reset=1 and done=0 next cycle; the concurrent word is dropped; a new load starts at address 0.
REQ-038 SHALL cover: reset=0 asserted mid-HOLD -> all outputs at reset values immediately (asynchronous, no clock edge required); after release a 1-word program loads to address 0.
